// File: rtl/umem_arbiter.sv
// Shares one single-port unified memory between the fetch port and the data port.
// A read holds the memory for LAT+1 cycles, a store for one cycle; stalls are combinational.
module umem_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    port_t       last_grant_q, last_grant_d;
    port_t       port_q, port_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic gnt_i, gnt_d, port_req;
    logic fetch_done, load_done, store_issue;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        addr_d       = addr_q;
        drop_d       = drop_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        fetch_done   = 1'b0;
        load_done    = 1'b0;
        store_issue  = 1'b0;
        m_en         = 1'b0;
        m_we         = 1'b0;
        m_addr       = addr_q;
        m_wdata      = 32'h0;
        port_req     = (port_q == PORT_I) ? i_req : d_req;

        case (state_q)
            IDLE: begin
                // On contention the port that did not win last time gets the memory.
                gnt_i = i_req && (!d_req || last_grant_q == PORT_D);
                gnt_d = d_req && (!i_req || last_grant_q == PORT_I);
                if (gnt_i || gnt_d) begin
                    m_en         = 1'b1;
                    m_we         = gnt_d && d_we;
                    m_addr       = gnt_d ? d_addr : i_addr;
                    m_wdata      = gnt_d ? d_wdata : 32'h0;
                    port_d       = gnt_d ? PORT_D : PORT_I;
                    last_grant_d = gnt_d ? PORT_D : PORT_I;
                    addr_d       = m_addr;
                    drop_d       = 1'b0;
                    store_issue  = m_we;
                    if (!m_we) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Once the owner lets go, the read still finishes but its data is thrown away.
                if (!port_req) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                    if (port_req && !drop_q) begin
                        fetch_done = (port_q == PORT_I);
                        load_done  = (port_q == PORT_D);
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fetch_done) begin
            i_rdata_d = m_rdata;
        end
        if (load_done) begin
            d_rdata_d = m_rdata;
        end

        if (reset) begin
            fetch_done  = 1'b0;
            load_done   = 1'b0;
            store_issue = 1'b0;
            m_en        = 1'b0;
            m_we        = 1'b0;
            m_addr      = 32'h0;
            m_wdata     = 32'h0;
        end

        i_stall = !reset && i_req && !fetch_done;
        d_stall = !reset && d_req && !(load_done || store_issue);
        i_rdata = reset ? 32'h0 : (fetch_done ? m_rdata : i_rdata_q);
        d_rdata = reset ? 32'h0 : (load_done ? m_rdata : d_rdata_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_grant_q <= PORT_D;
            port_q       <= PORT_I;
            addr_q       <= 32'h0;
            drop_q       <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            drop_q       <= drop_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule
